led_slot_sched: RTL and testbench

Time-slot scheduler that shares the 8-LED bank among four independent requesters (pattern generators, status reporters, debug probes). Each requester asks for the bank with an 8-bit pattern and a hold time in ticks. The block grants the bank round-robin, drives the active-low LED pins with the winner's pattern for exactly that long, and then inserts a blank gap. It sits between the per-function pattern blocks and the board LED pins and replaces direct pin ownership.

---
 rtl/led_slot_sched.sv | 138 +++++++++++++
 tb/tb_led_slot_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_slot_sched.sv
// Round-robin time-slot scheduler sharing an active-low 8-LED bank among four requesters.
// Each grant drives the winner's pattern for max(dur,1) ticks, then blanks for GAP_TICKS ticks.
module led_slot_sched #(
  parameter int unsigned TICK_DIV  = 12_000,
  parameter int unsigned GAP_TICKS = 1
) (
  input  logic        clk_x1,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] pat,
  input  logic [31:0] dur,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        busy,
  output logic [7:0]  led
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_TICKS);

  state_t      r_state, w_state_nxt;
  logic [23:0] r_presc, w_presc_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic [3:0]  r_gnt, w_gnt_nxt;
  logic [3:0]  r_done, w_done_nxt;
  logic [7:0]  r_led, w_led_nxt;

  logic        w_tick;
  logic        w_any;
  logic [1:0]  w_win;
  logic [7:0]  w_pat_sel;
  logic [7:0]  w_dur_sel;

  assign w_tick    = (r_presc == TICK_LAST);
  assign w_pat_sel = pat[{w_win, 3'b000} +: 8];
  assign w_dur_sel = dur[{w_win, 3'b000} +: 8];

  // Scan from furthest to nearest offset so the requester right after the last winner wins.
  always_comb begin
    w_any = 1'b0;
    w_win = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_last + 2'(k + 1)]) begin
        w_any = 1'b1;
        w_win = r_last + 2'(k + 1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = w_tick ? 24'd0 : r_presc + 24'd1;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 4'd0;
    w_led_nxt   = r_led;

    unique case (r_state)
      IDLE: begin
        w_gnt_nxt = 4'd0;
        w_led_nxt = 8'hFF;
        if (w_any) begin
          w_gnt_nxt   = 4'(1) << w_win;
          w_led_nxt   = ~w_pat_sel;
          w_cnt_nxt   = (w_dur_sel == 8'd0) ? 8'd1 : w_dur_sel;
          w_last_nxt  = w_win;
          w_presc_nxt = 24'd0;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // A dropped request ends the slot even if the final tick lands on the same cycle.
        if (!req[r_last]) begin
          w_gnt_nxt   = 4'd0;
          w_led_nxt   = 8'hFF;
          w_cnt_nxt   = GAP_LOAD;
          w_presc_nxt = 24'd0;
          w_state_nxt = GAP;
        end else if (w_tick) begin
          if (r_cnt == 8'd1) begin
            w_done_nxt  = 4'(1) << r_last;
            w_gnt_nxt   = 4'd0;
            w_led_nxt   = 8'hFF;
            w_cnt_nxt   = GAP_LOAD;
            w_presc_nxt = 24'd0;
            w_state_nxt = GAP;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
      end
      GAP: begin
        w_gnt_nxt = 4'd0;
        w_led_nxt = 8'hFF;
        if (w_tick) begin
          if (r_cnt == 8'd1) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_x1) begin
    if (rst) begin
      r_state <= IDLE;
      r_presc <= 24'd0;
      r_cnt   <= 8'd0;
      r_last  <= 2'd3;
      r_gnt   <= 4'd0;
      r_done  <= 4'd0;
      r_led   <= 8'hFF;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_led   <= w_led_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign led  = r_led;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_led_slot_sched.sv
// Scoreboard bench for led_slot_sched: stimulus queues expected slot records,
// a negedge monitor reconstructs each observed slot and compares it.
module tb_led_slot_sched;

  localparam int TICK_DIV  = 4;
  localparam int GAP_TICKS = 1;

  logic        clk_x1 = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [31:0] dur;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [7:0]  led;

  led_slot_sched #(
    .TICK_DIV (TICK_DIV),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk_x1(clk_x1),
    .rst   (rst),
    .req   (req),
    .pat   (pat),
    .dur   (dur),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .led   (led)
  );

  always #5 clk_x1 = ~clk_x1;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] led;
    int         hold;
    logic [3:0] done;
    int         gap;
  } slot_t;

  slot_t expQ[$];
  int vectors     = 0;
  int miscompares = 0;

  bit         inSlot = 1'b0;
  bit         inGap  = 1'b0;
  bit         stable;
  logic [3:0] curGnt;
  logic [7:0] curLed;
  logic [3:0] doneAcc;
  int         holdLen;
  int         gapLen;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqV);
    req = reqV;
  endtask

  task automatic expectSlot(input logic [3:0] g, input logic [7:0] l, input int h,
                            input logic [3:0] d, input int gp);
    slot_t s;
    s.gnt  = g;
    s.led  = l;
    s.hold = h;
    s.done = d;
    s.gap  = gp;
    expQ.push_back(s);
  endtask

  task automatic finishSlot();
    slot_t e;
    inSlot = 1'b0;
    inGap  = 1'b0;
    if (expQ.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL unexpected slot: got gnt %0h, expected no slot", curGnt);
    end else begin
      e = expQ.pop_front();
      checkOutput("slot gnt", 32'(curGnt), 32'(e.gnt));
      checkOutput("slot led", 32'(curLed), 32'(e.led));
      checkOutput("slot hold cycles", 32'(holdLen), 32'(e.hold));
      checkOutput("slot done", 32'(doneAcc), 32'(e.done));
      checkOutput("slot gap cycles", 32'(gapLen), 32'(e.gap));
      checkOutput("slot outputs stable", 32'(stable), 32'd1);
    end
  endtask

  // Rebuild each slot from the pins: hold length, pattern, done pulses and gap length.
  always @(negedge clk_x1) begin
    if (!inSlot) begin
      if (gnt != 4'd0) begin
        inSlot  = 1'b1;
        inGap   = 1'b0;
        curGnt  = gnt;
        curLed  = led;
        holdLen = 1;
        gapLen  = 0;
        doneAcc = done;
        stable  = busy;
      end
    end else if (!inGap) begin
      doneAcc |= done;
      if (gnt != 4'd0) begin
        holdLen++;
        if (gnt != curGnt || led != curLed || !busy) stable = 1'b0;
      end else if (busy) begin
        inGap  = 1'b1;
        gapLen = 1;
        if (led != 8'hFF) stable = 1'b0;
      end else begin
        finishSlot();
      end
    end else begin
      doneAcc |= done;
      if (busy && gnt == 4'd0) begin
        gapLen++;
        if (led != 8'hFF) stable = 1'b0;
      end else begin
        finishSlot();
      end
    end
  end

  task automatic waitDone(input logic [3:0] mask, input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk_x1);
      if (done == mask) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait done: got timeout, expected done %0h", mask);
    end
  endtask

  task automatic waitIdle(input int limit);
    bit seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk_x1);
      if (!busy) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL wait idle: got busy timeout, expected busy 0");
    end
    repeat (2) @(negedge clk_x1);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'hF);
    pat = {8'h44, 8'h33, 8'h22, 8'h11};
    dur = {4{8'd1}};

    for (int i = 0; i < 3; i++) begin
      @(negedge clk_x1);
      checkOutput("reset led", 32'(led), 32'hFF);
      checkOutput("reset gnt", 32'(gnt), 32'h0);
      checkOutput("reset done", 32'(done), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
    end

    // Round-robin with every request held: 0,1,2,3,0,1.
    expectSlot(4'b0001, 8'hEE, 4, 4'b0001, 4);
    expectSlot(4'b0010, 8'hDD, 4, 4'b0010, 4);
    expectSlot(4'b0100, 8'hCC, 4, 4'b0100, 4);
    expectSlot(4'b1000, 8'hBB, 4, 4'b1000, 4);
    expectSlot(4'b0001, 8'hEE, 4, 4'b0001, 4);
    expectSlot(4'b0010, 8'hDD, 4, 4'b0010, 4);
    rst = 1'b0;
    waitDone(4'b0001, 30);
    waitDone(4'b0010, 30);
    waitDone(4'b0100, 30);
    waitDone(4'b1000, 30);
    waitDone(4'b0001, 30);
    waitDone(4'b0010, 30);
    applyStimulus(4'b0000);
    waitIdle(40);

    // Single slot on requester 0.
    pat[7:0] = 8'hA5;
    dur[7:0] = 8'd3;
    expectSlot(4'b0001, 8'h5A, 12, 4'b0001, 4);
    applyStimulus(4'b0001);
    @(negedge clk_x1);
    checkOutput("grant latency gnt", 32'(gnt), 32'h1);
    checkOutput("grant latency led", 32'(led), 32'h5A);
    checkOutput("grant latency busy", 32'(busy), 32'h1);
    waitDone(4'b0001, 40);
    applyStimulus(4'b0000);
    waitIdle(40);

    // Zero duration behaves as one tick.
    pat[23:16] = 8'h0F;
    dur[23:16] = 8'd0;
    expectSlot(4'b0100, 8'hF0, 4, 4'b0100, 4);
    applyStimulus(4'b0100);
    waitDone(4'b0100, 30);
    applyStimulus(4'b0000);
    waitIdle(40);

    // Early release on cycle 6 of a long slot.
    pat[15:8] = 8'h3C;
    dur[15:8] = 8'd10;
    expectSlot(4'b0010, 8'hC3, 6, 4'b0000, 4);
    applyStimulus(4'b0010);
    @(negedge clk_x1);
    checkOutput("early grant", 32'(gnt), 32'h2);
    repeat (5) @(negedge clk_x1);
    applyStimulus(4'b0000);
    @(negedge clk_x1);
    checkOutput("early release gnt", 32'(gnt), 32'h0);
    checkOutput("early release led", 32'(led), 32'hFF);
    checkOutput("early release busy", 32'(busy), 32'h1);
    waitIdle(40);

    // Reset on cycle 5 of a dur=5 slot, then arbitration restarts at requester 0.
    pat[23:16] = 8'h81;
    dur[23:16] = 8'd5;
    expectSlot(4'b0100, 8'h7E, 5, 4'b0000, 0);
    applyStimulus(4'b0100);
    @(negedge clk_x1);
    checkOutput("midslot grant", 32'(gnt), 32'h4);
    repeat (4) @(negedge clk_x1);
    rst = 1'b1;
    applyStimulus(4'b0000);
    @(negedge clk_x1);
    checkOutput("midslot reset led", 32'(led), 32'hFF);
    checkOutput("midslot reset gnt", 32'(gnt), 32'h0);
    checkOutput("midslot reset done", 32'(done), 32'h0);
    checkOutput("midslot reset busy", 32'(busy), 32'h0);
    @(negedge clk_x1);
    rst = 1'b0;
    dur[7:0] = 8'd2;
    expectSlot(4'b0001, 8'h5A, 8, 4'b0001, 4);
    applyStimulus(4'b1001);
    waitDone(4'b0001, 40);
    applyStimulus(4'b0000);
    waitIdle(40);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
